mnist_image_feeder: RTL and testbench

Host-side initiator for the MNIST inference core. Accepts one 8×8 grayscale image as 64 byte-wide pixels over a valid/ready stream, quantizes each pixel to 2 bits, and packs four pixels per byte into a 16-byte buffer. It then drives the core's start/pixel-load protocol and waits for the core's done flag. The captured prediction is returned on a valid/ready result port. It sits between the chip I/O / host interface and the inference core.

---
 rtl/mnist_image_feeder.sv | 118 +++++++++++
 tb/tb_mnist_image_feeder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_image_feeder.sv
// Collects one 8x8 image, quantizes pixels to 2 bits, streams 16 packed words to the
// inference core and returns its prediction. Define FEEDER_TIMEOUT_EN to add a WAIT watchdog.
module mnist_image_feeder #(
  parameter int THR1           = 64,
  parameter int THR2           = 128,
  parameter int THR3           = 192,
  parameter int TIMEOUT_CYCLES = 8191
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       nn_start,
  output logic [7:0] nn_pixels,
  input  logic       nn_done,
  input  logic [3:0] nn_prediction,
  output logic       r_valid,
  input  logic       r_ready,
  output logic [3:0] r_digit,
  output logic       r_error,
  output logic       busy
);

  typedef enum logic [2:0] {COLLECT, START, STREAM, WAIT, RESULT} state_t;

  localparam logic [8:0] T1 = 9'(THR1);
  localparam logic [8:0] T2 = 9'(THR2);
  localparam logic [8:0] T3 = 9'(THR3);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must fit the 13-bit watchdog counter");
  end

  state_t     state, state_next;
  logic [5:0] pix_cnt;
  logic [3:0] w;
  logic [3:0] rd_idx;
  logic [1:0] quant;
  logic       accept;
  logic [7:0] pix_buf [16];

  assign quant = ({1'b0, s_data} < T1) ? 2'd0 :
                 ({1'b0, s_data} < T2) ? 2'd1 :
                 ({1'b0, s_data} < T3) ? 2'd2 : 2'd3;

  assign s_ready = (state == COLLECT);
  // Word to present next cycle: word 0 when leaving START, otherwise the one after w.
  assign rd_idx  = (state == STREAM) ? w + 4'd1 : 4'd0;

`ifdef FEEDER_TIMEOUT_EN
  localparam logic [12:0] TIMEOUT_LIMIT = 13'(TIMEOUT_CYCLES);
  logic [12:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             wd_cnt <= '0;
    else if (state != WAIT) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 13'd1;
  end
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      COLLECT: begin
        if (s_valid) begin
          accept = 1'b1;
          if (pix_cnt == 6'd63) state_next = START;
        end
      end
      START:  state_next = STREAM;
      STREAM: if (w == 4'd15) state_next = WAIT;
      WAIT: begin
        if (nn_done) state_next = RESULT;
`ifdef FEEDER_TIMEOUT_EN
        else if (wd_cnt == TIMEOUT_LIMIT) state_next = RESULT;
`endif
      end
      RESULT:  if (r_ready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Image buffer has no reset: every slot is rewritten before the next stream.
  always_ff @(posedge clk) begin
    if (accept) pix_buf[pix_cnt[5:2]][{pix_cnt[1:0], 1'b0} +: 2] <= quant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      pix_cnt   <= '0;
      w         <= '0;
      nn_start  <= 1'b0;
      nn_pixels <= '0;
      r_valid   <= 1'b0;
      r_digit   <= '0;
      r_error   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_next;
      nn_start <= (state_next == START);
      r_valid  <= (state_next == RESULT);
      busy     <= (state_next != COLLECT);
      if (accept) pix_cnt <= pix_cnt + 6'd1;
      if (state == START)       w <= '0;
      else if (state == STREAM) w <= w + 4'd1;
      nn_pixels <= (state_next == STREAM) ? pix_buf[rd_idx] : 8'h00;
      // Leaving WAIT without nn_done can only be a watchdog expiry.
      if (state == WAIT && state_next == RESULT) begin
        r_digit <= nn_done ? nn_prediction : 4'hF;
        r_error <= !nn_done;
      end
    end
  end

endmodule

// File: tb/tb_mnist_image_feeder.sv
// Randomized bench for mnist_image_feeder: a cycle-timeline model predicts every output,
// plus literal checks for the ramp, threshold, backpressure, reset and watchdog cases.
module tb_mnist_image_feeder;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       nn_done = 1'b0;
  logic [3:0] nn_prediction = '0;
  logic       r_ready = 1'b0;
  logic       s_ready, nn_start, r_valid, r_error, busy;
  logic [7:0] nn_pixels;
  logic [3:0] r_digit;

  always #5 clk = ~clk;

  mnist_image_feeder #(
    .THR1(64), .THR2(128), .THR3(192), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .nn_start(nn_start), .nn_pixels(nn_pixels),
    .nn_done(nn_done), .nn_prediction(nn_prediction),
    .r_valid(r_valid), .r_ready(r_ready), .r_digit(r_digit), .r_error(r_error),
    .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_ready = 1'b0;
  bit         m_collect;
  int         m_n;
  int         m_k;       // edges since the 64th accept (0 = start cycle)
  bit         m_result;
  logic [3:0] m_digit;
  bit         m_err;
  logic [1:0] m_q [64];

  function automatic logic [1:0] quant(input logic [7:0] p);
    if (p < 64)       return 2'd0;
    else if (p < 128) return 2'd1;
    else if (p < 192) return 2'd2;
    else              return 2'd3;
  endfunction

  function automatic logic [7:0] word(input int j);
    return {m_q[4*j+3], m_q[4*j+2], m_q[4*j+1], m_q[4*j]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready  <= 1'b1;
      m_collect <= 1'b1;
      m_n      <= 0;
      m_k      <= 0;
      m_result <= 1'b0;
      m_digit  <= 4'h0;
      m_err    <= 1'b0;
    end else if (m_collect) begin
      if (s_valid) begin
        m_q[m_n] <= quant(s_data);
        if (m_n == 63) begin
          m_n <= 0;
          m_collect <= 1'b0;
          m_k <= 0;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end else if (m_result) begin
      if (r_ready) begin
        m_result  <= 1'b0;
        m_collect <= 1'b1;
      end
    end else if (m_k >= 17 && nn_done) begin
      m_result <= 1'b1;
      m_digit  <= nn_prediction;
      m_err    <= 1'b0;
    end
`ifdef FEEDER_TIMEOUT_EN
    else if (m_k - 17 == TO) begin
      m_result <= 1'b1;
      m_digit  <= 4'hF;
      m_err    <= 1'b1;
    end
`endif
    else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      bit         active;
      logic [7:0] exp_pix;
      active  = !m_collect && !m_result;
      exp_pix = (active && m_k >= 1 && m_k <= 16) ? word(m_k - 1) : 8'h00;
      check("s_ready",   s_ready,   m_collect);
      check("busy",      busy,      !m_collect);
      check("nn_start",  nn_start,  active && m_k == 0);
      check("nn_pixels", nn_pixels, exp_pix);
      check("r_valid",   r_valid,   m_result);
      check("r_digit",   r_digit,   m_digit);
      check("r_error",   r_error,   m_err);
    end
  end

  // ---------------- stimulus ----------------
  bit core_auto = 1'b0;
  bit rr_auto   = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (core_auto) begin
      nn_done       = ($urandom_range(0, 3) == 0);
      nn_prediction = 4'($urandom_range(0, 15));
    end
    if (rr_auto) r_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_image(input logic [7:0] px [64], input bit gaps);
    for (int i = 0; i < 64; i++) begin
      bit rdy;
      int b;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          s_valid = 1'b0;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = px[i];
      b = 0;
      do begin
        rdy = s_ready;
        tick();
        b++;
      end while (!rdy && b < 400);
      if (!rdy) check("accept_timeout", 0, 1);
    end
    s_valid = 1'b0;
    $display("image sent, first pixels %0d %0d %0d %0d", px[0], px[1], px[2], px[3]);
  endtask

  logic [7:0] img [64];
  logic [7:0] ramp_exp [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55, 8'h55, 8'h55,
                                8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] thr_px [8] = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255, 8'd0};

  initial begin
    repeat (3) tick();
    #1 rst_n = 1'b1;
    tick();
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_nn_start", nn_start, 0);
    check("rst_nn_pixels", nn_pixels, 0);
    check("rst_r_digit", r_digit, 0);
    check("rst_r_error", r_error, 0);

    // Pixel ramp, back-to-back
    core_auto = 1'b1;
    rr_auto   = 1'b1;
    for (int i = 0; i < 64; i++) img[i] = 8'(i * 4);
    send_image(img, 1'b0);
    check("ramp_start", nn_start, 1);
    for (int j = 0; j < 16; j++) begin
      tick();
      check($sformatf("ramp_word%0d", j), nn_pixels, ramp_exp[j]);
    end

    // Threshold edges
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) img[i] = thr_px[i];
    send_image(img, 1'b1);
    check("thr_start", nn_start, 1);
    tick();
    check("thr_word0", nn_pixels, 8'h94);
    tick();
    check("thr_word1", nn_pixels, 8'h3E);

    // Gapped random images
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
      send_image(img, 1'b1);
    end

    // Result backpressure
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    send_image(img, 1'b1);
    rr_auto = 1'b0;
    r_ready = 1'b0;
    begin
      int b;
      logic [3:0] d;
      b = 0;
      while (!r_valid && b < 300) begin
        tick();
        b++;
      end
      check("bp_r_valid_seen", r_valid, 1);
      d = r_digit;
      for (int c = 0; c < 20; c++) begin
        tick();
        check("bp_r_valid", r_valid, 1);
        check("bp_r_digit", r_digit, d);
        check("bp_s_ready", s_ready, 0);
      end
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      check("bp_release_s_ready", s_ready, 1);
      check("bp_release_r_valid", r_valid, 0);
    end

    // Reset during STREAM at word 7
    rr_auto = 1'b1;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    send_image(img, 1'b1);
    repeat (8) tick();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_nn_start", nn_start, 0);
    check("mid_rst_nn_pixels", nn_pixels, 0);
    check("mid_rst_r_valid", r_valid, 0);
    check("mid_rst_s_ready", s_ready, 1);
    tick();
    tick();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    send_image(img, 1'b1);
    check("post_rst_start", nn_start, 1);
    begin
      int b;
      b = 0;
      while (!r_valid && b < 300) begin
        tick();
        b++;
      end
      check("post_rst_result", r_valid, 1);
    end

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog: core never answers
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
    send_image(img, 1'b1);
    core_auto = 1'b0;
    nn_done   = 1'b0;
    rr_auto   = 1'b0;
    r_ready   = 1'b0;
    begin
      int cnt;
      cnt = 0;
      while (!r_valid && cnt < 400) begin
        tick();
        cnt++;
      end
      check("wd_latency", cnt, 118);
      check("wd_r_error", r_error, 1);
      check("wd_r_digit", r_digit, 4'hF);
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
    end
`endif

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
